// File: rtl/softmax_feeder_if.sv
// Bus bundle for softmax_feeder: host write/start, argmax-core group/result, final result.
// low_conf_o is present only when SOFTMAX_FEEDER_LOWCONF_EN is defined.
interface softmax_feeder_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic [4:0] index_0, index_1, index_2, index_3;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic [4:0] index_i;
    logic [7:0] data_i;
    logic [4:0] class_o;
    logic [7:0] score_o;
    logic       done_o;
`ifdef SOFTMAX_FEEDER_LOWCONF_EN
    logic       low_conf_o;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, start, index_i, data_i,
        input  busy, index_0, index_1, index_2, index_3,
               data_0, data_1, data_2, data_3, class_o, score_o, done_o
`ifdef SOFTMAX_FEEDER_LOWCONF_EN
        , input low_conf_o
`endif
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, index_i, data_i,
        output busy, index_0, index_1, index_2, index_3,
               data_0, data_1, data_2, data_3, class_o, score_o, done_o
`ifdef SOFTMAX_FEEDER_LOWCONF_EN
        , output low_conf_o
`endif
    );
endinterface

// File: rtl/softmax_feeder.sv
// Streams a buffer of int8 logits to an external 4-wide argmax core and reduces its results.
// Optional low-confidence flag enabled by defining SOFTMAX_FEEDER_LOWCONF_EN.
module softmax_feeder #(
    parameter int unsigned       NUM_CLASSES = 24,
    parameter logic signed [7:0] CONF_THRESH = 8'sd0
) (
    input logic             clk,
    input logic             resetn,
    softmax_feeder_if.slave bus
);
    localparam int unsigned G        = (NUM_CLASSES + 3) / 4;
    localparam logic [2:0]  LAST_GRP = 3'(G - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_grp;
    logic [7:0]        r_mem [NUM_CLASSES];
    logic [4:0]        w_slot [4];
    logic [4:0]        w_idx  [4];
    logic [7:0]        w_dat  [4];
    logic              w_busy, w_sample, w_first;
    logic [4:0]        r_best_idx, w_best_idx_nxt;
    logic signed [7:0] r_best_dat, w_best_dat_nxt;
    logic [4:0]        r_class;
    logic [7:0]        r_score;
    logic              r_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = ISSUE;
            ISSUE:   if (r_grp == LAST_GRP) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != IDLE);
        w_sample = (r_state == ISSUE && r_grp != 3'd0) || (r_state == DRAIN);
        // With a single group the only result arrives in DRAIN.
        w_first  = (r_state == ISSUE && r_grp == 3'd1) ||
                   (r_state == DRAIN && LAST_GRP == 3'd0);
        for (int unsigned s = 0; s < 4; s++) begin
            w_slot[s] = {r_grp, 2'b00} + 5'(s);
            w_idx[s]  = '0;
            w_dat[s]  = '0;
            if (r_state == ISSUE) begin
                if (32'(w_slot[s]) < NUM_CLASSES) begin
                    w_idx[s] = w_slot[s];
                    w_dat[s] = r_mem[w_slot[s]];
                end else begin
                    w_idx[s] = {r_grp, 2'b00};
                    w_dat[s] = 8'h80;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                r_grp <= '0;
        else if (r_state == ISSUE)  r_grp <= r_grp + 3'd1;
        else                        r_grp <= '0;
    end

    // Buffer is deliberately left out of reset so logits survive an aborted pass.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.wr_en && 32'(bus.wr_addr) < NUM_CLASSES)
            r_mem[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        w_best_idx_nxt = r_best_idx;
        w_best_dat_nxt = r_best_dat;
        if (w_sample && (w_first || $signed(bus.data_i) > r_best_dat)) begin
            w_best_idx_nxt = bus.index_i;
            w_best_dat_nxt = $signed(bus.data_i);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_best_idx <= '0;
            r_best_dat <= '0;
        end else begin
            r_best_idx <= w_best_idx_nxt;
            r_best_dat <= w_best_dat_nxt;
        end
    end

    // The DRAIN result is folded in the same edge that publishes the answer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_class <= '0;
            r_score <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN);
            if (r_state == DRAIN) begin
                r_class <= w_best_idx_nxt;
                r_score <= w_best_dat_nxt;
            end
        end
    end

`ifdef SOFTMAX_FEEDER_LOWCONF_EN
    logic r_low_conf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               r_low_conf <= 1'b0;
        else if (r_state == DRAIN) r_low_conf <= (w_best_dat_nxt < CONF_THRESH);
    end

    assign bus.low_conf_o = r_low_conf;
`endif

    assign bus.busy    = w_busy;
    assign bus.index_0 = w_idx[0];
    assign bus.index_1 = w_idx[1];
    assign bus.index_2 = w_idx[2];
    assign bus.index_3 = w_idx[3];
    assign bus.data_0  = w_dat[0];
    assign bus.data_1  = w_dat[1];
    assign bus.data_2  = w_dat[2];
    assign bus.data_3  = w_dat[3];
    assign bus.class_o = r_class;
    assign bus.score_o = r_score;
    assign bus.done_o  = r_done;
endmodule

// File: tb/tb_softmax_feeder.sv
// Bench for softmax_feeder: 24- and 22-class instances, behavioural argmax core and model.
module tb_softmax_feeder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m24 [24];
    int   m22 [22];

    always #5 clk = ~clk;

    softmax_feeder_if if24();
    softmax_feeder_if if22();

    softmax_feeder #(.NUM_CLASSES(24), .CONF_THRESH(8'sd10)) u_dut24 (
        .clk(clk), .resetn(resetn), .bus(if24.slave));
    softmax_feeder #(.NUM_CLASSES(22)) u_dut22 (
        .clk(clk), .resetn(resetn), .bus(if22.slave));

    // External argmax core: registered winner, lowest slot wins ties.
    function automatic logic [12:0] pick(input logic [4:0] i0, i1, i2, i3,
                                         input logic [7:0] d0, d1, d2, d3);
        logic [4:0]        bi;
        logic signed [7:0] bd;
        bi = i0; bd = $signed(d0);
        if ($signed(d1) > bd) begin bi = i1; bd = $signed(d1); end
        if ($signed(d2) > bd) begin bi = i2; bd = $signed(d2); end
        if ($signed(d3) > bd) begin bi = i3; bd = $signed(d3); end
        return {bi, bd};
    endfunction

    always @(posedge clk) begin
        {if24.index_i, if24.data_i} <= pick(if24.index_0, if24.index_1, if24.index_2, if24.index_3,
                                            if24.data_0, if24.data_1, if24.data_2, if24.data_3);
        {if22.index_i, if22.data_i} <= pick(if22.index_0, if22.index_1, if22.index_2, if22.index_3,
                                            if22.data_0, if22.data_1, if22.data_2, if22.data_3);
    end

    function automatic logic [51:0] core_bus(input int d);
        if (d == 0)
            return {if24.index_0, if24.index_1, if24.index_2, if24.index_3,
                    if24.data_0, if24.data_1, if24.data_2, if24.data_3};
        return {if22.index_0, if22.index_1, if22.index_2, if22.index_3,
                if22.data_0, if22.data_1, if22.data_2, if22.data_3};
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? if24.busy : if22.busy;
    endfunction

    function automatic logic done_of(input int d);
        return (d == 0) ? if24.done_o : if22.done_o;
    endfunction

    // Reference: lowest index holding the maximum signed logit.
    function automatic void model_best(input int d, output int cls, output int sc);
        int n = (d == 0) ? 24 : 22;
        cls = 0;
        sc  = (d == 0) ? m24[0] : m22[0];
        for (int i = 1; i < n; i++) begin
            int v = (d == 0) ? m24[i] : m22[i];
            if (v > sc) begin cls = i; sc = v; end
        end
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        for (int k = 0; k < 4 && busy_of(d); k++) tick;
    endtask

    task automatic wr(input int d, input int a, input int v);
        wait_idle(d);
        if (d == 0) begin if24.wr_en = 1'b1; if24.wr_addr = 5'(a); if24.wr_data = 8'(v); end
        else        begin if22.wr_en = 1'b1; if22.wr_addr = 5'(a); if22.wr_data = 8'(v); end
        tick;
        if24.wr_en = 1'b0;
        if22.wr_en = 1'b0;
        if (d == 0 && a < 24) m24[a] = v;
        if (d == 1 && a < 22) m22[a] = v;
    endtask

    task automatic wait_done(input int d, input int c0, output int lat);
        lat = -1;
        for (int c = c0; c <= 40; c++) begin
            if (done_of(d)) begin lat = c; break; end
            tick;
        end
    endtask

    task automatic go(input int d, output int lat);
        wait_idle(d);
        if (d == 0) if24.start = 1'b1; else if22.start = 1'b1;
        tick;
        if24.start = 1'b0;
        if22.start = 1'b0;
        wait_done(d, 1, lat);
    endtask

    task automatic test_reset;
        #13;
        n_tests++; if (if24.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", if24.busy); end
        n_tests++; if (if24.done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", if24.done_o); end
        n_tests++; if (if24.class_o !== 5'd0 || if24.score_o !== 8'd0) begin
            n_fail++; $display("FAIL rst_result got=%0d/%0d exp=0/0", if24.class_o, if24.score_o); end
        n_tests++; if (core_bus(0) !== 52'd0) begin n_fail++; $display("FAIL rst_core got=%h exp=0", core_bus(0)); end
        @(negedge clk) resetn = 1'b1;
        tick;
        n_tests++; if (core_bus(0) !== 52'd0 || core_bus(1) !== 52'd0) begin
            n_fail++; $display("FAIL rst_release_core got=%h/%h exp=0", core_bus(0), core_bus(1)); end
    endtask

    task automatic test_peak;
        int lat;
        for (int i = 0; i < 24; i++) wr(0, i, -5);
        wr(0, 17, 40);
        go(0, lat);
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL peak_latency got=%0d exp=8", lat); end
        n_tests++; if (if24.class_o !== 5'd17) begin n_fail++; $display("FAIL peak_class got=%0d exp=17", if24.class_o); end
        n_tests++; if (if24.score_o !== 8'd40) begin n_fail++; $display("FAIL peak_score got=%0d exp=40", if24.score_o); end
        n_tests++; if (if24.busy !== 1'b1) begin n_fail++; $display("FAIL peak_busy_done got=%b exp=1", if24.busy); end
        tick;
        n_tests++; if (if24.done_o !== 1'b0 || if24.busy !== 1'b0) begin
            n_fail++; $display("FAIL peak_pulse got=%b/%b exp=0/0", if24.done_o, if24.busy); end
    endtask

    task automatic test_tie;
        int lat;
        for (int i = 0; i < 24; i++) wr(0, i, -1);
        wr(0, 3, 12);
        wr(0, 20, 12);
        go(0, lat);
        n_tests++; if (if24.class_o !== 5'd3) begin n_fail++; $display("FAIL tie_class got=%0d exp=3", if24.class_o); end
        n_tests++; if (if24.score_o !== 8'd12) begin n_fail++; $display("FAIL tie_score got=%0d exp=12", if24.score_o); end
    endtask

    task automatic test_random;
        int lat, ec, es;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 24; i++)
                wr(0, i, (it % 2 == 0) ? rnd(-128, 127) : rnd(-2, 1));
            for (int j = 0; j < 3; j++) wr(0, rnd(24, 31), 127);
            model_best(0, ec, es);
            go(0, lat);
            n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL rand_latency it=%0d got=%0d exp=8", it, lat); end
            n_tests++; if (if24.class_o !== 5'(ec)) begin
                n_fail++; $display("FAIL rand_class it=%0d got=%0d exp=%0d", it, if24.class_o, ec); end
            n_tests++; if (if24.score_o !== 8'(es)) begin
                n_fail++; $display("FAIL rand_score it=%0d got=%0d exp=%0d", it, $signed(if24.score_o), es); end
        end
    endtask

    task automatic test_pad22;
        int lat, ec, es;
        for (int i = 0; i < 22; i++) wr(1, i, -128);
        wr(1, 22, 127);
        wr(1, 23, 127);
        go(1, lat);
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL pad_latency got=%0d exp=8", lat); end
        n_tests++; if (if22.class_o !== 5'd0) begin n_fail++; $display("FAIL pad_class got=%0d exp=0", if22.class_o); end
        n_tests++; if (if22.score_o !== 8'h80) begin n_fail++; $display("FAIL pad_score got=%h exp=80", if22.score_o); end
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 22; i++) wr(1, i, rnd(-128, -120));
            model_best(1, ec, es);
            go(1, lat);
            n_tests++; if (if22.class_o !== 5'(ec) || if22.score_o !== 8'(es)) begin
                n_fail++; $display("FAIL pad_rand it=%0d got=%0d/%0d exp=%0d/%0d", it,
                                   if22.class_o, $signed(if22.score_o), ec, es); end
        end
    endtask

    task automatic test_same_edge;
        int lat;
        for (int i = 0; i < 24; i++) wr(0, i, -3);
        wait_idle(0);
        if24.wr_en = 1'b1; if24.wr_addr = 5'd9; if24.wr_data = 8'h7f; if24.start = 1'b1;
        tick;
        if24.wr_en = 1'b0; if24.start = 1'b0;
        m24[9] = 127;
        wait_done(0, 1, lat);
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL same_latency got=%0d exp=8", lat); end
        n_tests++; if (if24.class_o !== 5'd9 || if24.score_o !== 8'h7f) begin
            n_fail++; $display("FAIL same_result got=%0d/%h exp=9/7f", if24.class_o, if24.score_o); end
    endtask

    task automatic test_busy_ignore;
        int lat, ec, es, n_act;
        for (int i = 0; i < 24; i++) wr(0, i, rnd(-100, 100));
        model_best(0, ec, es);
        wait_idle(0);
        if24.start = 1'b1;
        tick;
        if24.start = 1'b0;
        tick;
        if24.start = 1'b1; if24.wr_en = 1'b1; if24.wr_addr = 5'd5; if24.wr_data = 8'h7f;
        tick;
        if24.start = 1'b0; if24.wr_en = 1'b0;
        wait_done(0, 3, lat);
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL busy_latency got=%0d exp=8", lat); end
        n_tests++; if (if24.class_o !== 5'(ec) || if24.score_o !== 8'(es)) begin
            n_fail++; $display("FAIL busy_result got=%0d/%0d exp=%0d/%0d", if24.class_o, $signed(if24.score_o), ec, es); end
        n_act = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (if24.busy || if24.done_o) n_act++;
        end
        n_tests++; if (n_act !== 0) begin n_fail++; $display("FAIL busy_restart got=%0d active cycles exp=0", n_act); end
        n_tests++; if (if24.class_o !== 5'(ec)) begin n_fail++; $display("FAIL busy_hold got=%0d exp=%0d", if24.class_o, ec); end
        go(0, lat);
        n_tests++; if (if24.class_o !== 5'(ec) || if24.score_o !== 8'(es)) begin
            n_fail++; $display("FAIL busy_nowrite got=%0d/%0d exp=%0d/%0d", if24.class_o, $signed(if24.score_o), ec, es); end
    endtask

    task automatic test_reset_mid;
        int lat, ec, es, n_act;
        model_best(0, ec, es);
        wait_idle(0);
        if24.start = 1'b1;
        tick;
        if24.start = 1'b0;
        tick;
        tick;
        n_tests++; if (if24.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", if24.busy); end
        resetn = 1'b0;
        #1;
        n_tests++; if (if24.busy !== 1'b0 || if24.done_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ctl got=%b/%b exp=0/0", if24.busy, if24.done_o); end
        n_tests++; if (if24.class_o !== 5'd0 || if24.score_o !== 8'd0 || core_bus(0) !== 52'd0) begin
            n_fail++; $display("FAIL mid_rst_out got=%0d/%0d/%h exp=0", if24.class_o, if24.score_o, core_bus(0)); end
        tick;
        tick;
        @(negedge clk) resetn = 1'b1;
        n_act = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (if24.busy || if24.done_o) n_act++;
        end
        n_tests++; if (n_act !== 0) begin n_fail++; $display("FAIL mid_no_done got=%0d active cycles exp=0", n_act); end
        go(0, lat);
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL mid_latency got=%0d exp=8", lat); end
        n_tests++; if (if24.class_o !== 5'(ec) || if24.score_o !== 8'(es)) begin
            n_fail++; $display("FAIL mid_result got=%0d/%0d exp=%0d/%0d", if24.class_o, $signed(if24.score_o), ec, es); end
    endtask

`ifdef SOFTMAX_FEEDER_LOWCONF_EN
    task automatic test_lowconf;
        int lat;
        for (int i = 0; i < 24; i++) wr(0, i, -20);
        wr(0, 4, 9);
        go(0, lat);
        n_tests++; if (if24.low_conf_o !== 1'b1) begin n_fail++; $display("FAIL lowconf_9 got=%b exp=1", if24.low_conf_o); end
        wr(0, 4, 10);
        go(0, lat);
        n_tests++; if (if24.low_conf_o !== 1'b0) begin n_fail++; $display("FAIL lowconf_10 got=%b exp=0", if24.low_conf_o); end
    endtask
`endif

    initial begin
        if24.wr_en = 1'b0; if24.wr_addr = '0; if24.wr_data = '0; if24.start = 1'b0;
        if22.wr_en = 1'b0; if22.wr_addr = '0; if22.wr_data = '0; if22.start = 1'b0;
        test_reset;
        test_peak;
        test_tie;
        test_random;
        test_pad22;
        test_same_edge;
        test_busy_ignore;
        test_reset_mid;
`ifdef SOFTMAX_FEEDER_LOWCONF_EN
        test_lowconf;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
